// File: rtl/multi_stride_counter_if.sv
// Bundle of the per-channel control inputs and registered status outputs of
// multi_stride_counter. Channel i occupies bits [i*WIDTH +: WIDTH] of every
// packed multi-channel field.
//
// Transfer semantics: there is no valid/ready pair. en/clr/ld act as
// per-channel level-sensitive qualifiers sampled on every posedge of clk,
// with priority clr > ld > en > hold. Outputs are always valid once reset
// is released.
interface multi_stride_counter_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       clr;
  logic [CHANNELS-1:0]       ld;
  logic [CHANNELS*WIDTH-1:0] ld_val;
  logic [CHANNELS*WIDTH-1:0] stride;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       wrap;
  logic [CHANNELS-1:0]       sat;
  logic [WIDTH-1:0]          ticks;

  modport master (
    output en, clr, ld, ld_val, stride,
    input  count, wrap, sat, ticks
  );

  modport slave (
    input  en, clr, ld, ld_val, stride,
    output count, wrap, sat, ticks
  );
endinterface

// File: rtl/multi_stride_counter.sv
// Bank of independent stride counters plus a free-running tick counter.
// Each channel adds its own stride when enabled, either wrapping (with a
// one-cycle wrap pulse) or saturating at all-ones (with a sticky sat flag).
// All outputs come straight from flops.
module multi_stride_counter #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter bit SATURATE = 1'b0
) (
  input logic                  clk,
  input logic                  rst,
  multi_stride_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q [CHANNELS];
  logic             wrap_q  [CHANNELS];
  logic             sat_q   [CHANNELS];
  logic [WIDTH-1:0] ticks_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] stride_i;
    logic [WIDTH:0]   sum;

    assign stride_i = bus.stride[i*WIDTH +: WIDTH];
    // Extra bit captures the carry out of the add.
    assign sum      = {1'b0, count_q[i]} + {1'b0, stride_i};

    // Channel update with priority clr > ld > en > hold.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q[i] <= '0;
        wrap_q[i]  <= 1'b0;
        sat_q[i]   <= 1'b0;
      end else if (bus.clr[i]) begin
        count_q[i] <= '0;
        wrap_q[i]  <= 1'b0;
        sat_q[i]   <= 1'b0;
      end else if (bus.ld[i]) begin
        // Loading keeps the sticky saturation history.
        count_q[i] <= bus.ld_val[i*WIDTH +: WIDTH];
        wrap_q[i]  <= 1'b0;
      end else if (bus.en[i]) begin
        if (SATURATE) begin
          // Already at all-ones with non-zero stride also carries, so it
          // lands here and simply holds all-ones.
          if (sum[WIDTH]) begin
            count_q[i] <= '1;
            sat_q[i]   <= 1'b1;
          end else begin
            count_q[i] <= sum[WIDTH-1:0];
          end
          wrap_q[i] <= 1'b0;
        end else begin
          count_q[i] <= sum[WIDTH-1:0];
          wrap_q[i]  <= sum[WIDTH];
        end
      end else begin
        wrap_q[i] <= 1'b0;
      end
    end
  end

  // Free-running cycle counter, independent of channel controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ticks_q <= '0;
    end else begin
      ticks_q <= ticks_q + 1'b1;
    end
  end

  // Pack per-channel flops onto the interface outputs (wiring only).
  always_comb begin
    bus.count = '0;
    bus.wrap  = '0;
    bus.sat   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.count[i*WIDTH +: WIDTH] = count_q[i];
      bus.wrap[i]                 = wrap_q[i];
      bus.sat[i]                  = sat_q[i];
    end
    bus.ticks = ticks_q;
  end

endmodule

// File: doc/multi_stride_counter.md
MULTI_STRIDE_COUNTER -- requirements
Module: multi_stride_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the bit width of each channel counter and of the tick counter.
REQ-002 SHALL have parameter CHANNELS, default 2, giving the number of independent counter channels (legal range 1..16).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap on overflow, 1 = saturate at all-ones.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, CHANNELS, per-channel count enable.
REQ-007 SHALL have port clr, input, CHANNELS, per-channel synchronous clear.
REQ-008 SHALL have port ld, input, CHANNELS, per-channel synchronous load.
REQ-009 SHALL have port ld_val, input, CHANNELS*WIDTH, load values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port stride, input, CHANNELS*WIDTH, per-channel increment, same slicing.
REQ-011 SHALL have port count, output, CHANNELS*WIDTH, registered channel values, same slicing.
REQ-012 SHALL have port wrap, output, CHANNELS, registered one-cycle overflow pulse per channel (SATURATE=0).
REQ-013 SHALL have port sat, output, CHANNELS, registered sticky saturation flag per channel (SATURATE=1; constant 0 otherwise).
REQ-014 SHALL have port ticks, output, WIDTH, registered free-running cycle counter.

Function
REQ-015 Per channel, per posedge, SHALL apply priority clr > ld > en > hold.
REQ-016 clr[i]=1 SHALL set count[i]=0, wrap[i]=0, sat[i]=0 on the next edge.
REQ-017 ld[i]=1 (clr[i]=0) SHALL set count[i]=ld_val[i], wrap[i]=0, and leave sat[i] unchanged.
REQ-018 en[i]=1 (clr, ld low) SHALL compute sum = count[i] + stride[i] at WIDTH+1 bits; carry = sum[WIDTH].
REQ-019 SATURATE=0, carry=0: count[i] <= sum[WIDTH-1:0], wrap[i] <= 0.
REQ-020 SATURATE=0, carry=1: count[i] <= sum[WIDTH-1:0] (modulo 2^WIDTH), wrap[i] <= 1 for exactly one cycle.
REQ-021 SATURATE=1, carry=1: count[i] <= all-ones, sat[i] <= 1; sat[i] remains set until clr[i] or rst.
REQ-022 SATURATE=1, count[i] already all-ones with stride[i] != 0: count[i] SHALL hold and sat[i] SHALL be 1.
REQ-023 stride[i]=0 with en[i]=1 SHALL hold count[i] and never assert wrap[i].
REQ-024 Idle channel (en, clr, ld low) SHALL hold count[i] and drive wrap[i]=0.
REQ-025 Channels SHALL be fully independent; no input of channel j affects channel i != j.
REQ-026 ticks SHALL increment by 1 every posedge when not in reset, wrapping from 2^WIDTH-1 to 0; it is unaffected by en/clr/ld.
REQ-027 All outputs SHALL be driven directly from flops, with no combinational input-to-output path.
REQ-028 wrap[i] SHALL never be 1 on two consecutive cycles unless a carry occurs on both of the corresponding updates.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force count=0, wrap=0, sat=0, ticks=0.
REQ-030 While rst=1, all inputs SHALL be ignored; on the first posedge after rst falls, normal REQ-015 processing SHALL apply.
REQ-031 Assertion of rst mid-operation SHALL discard all in-flight state; no pulse SHALL survive reset.

Verification
REQ-032 Defaults, stride0=1, stride1=2, en=2'b11 from reset release -> at cycle k: count0=k, count1=2k, ticks=k; with count0==0 |-> count1==0, and count0==1 |-> count1==2.
REQ-033 WIDTH=8, SATURATE=0, ld 254, then stride 3, en=1 -> count 1, wrap=1 for one cycle; next step count 4, wrap=0.
REQ-034 WIDTH=8, SATURATE=1, ld 250, then stride 10, en=1 -> count 255, sat=1 and sticky over 5 more cycles; clr -> count 0, sat 0.
REQ-035 clr=1, ld=1, en=1 in the same cycle on one channel, ld_val=77 -> count 0; the other channel is unaffected.
REQ-036 Async rst pulsed between edges while count=9, ticks=9 -> count, ticks, wrap and sat read 0 before the next posedge; counting resumes from 0 after release.
